io_bus_responder: RTL and testbench

//  Memory-mapped responder on the CPU IO_BUS (io_addr/io_dout/io_we/io_rd/io_din); the target the CPU drives.

---
 rtl/io_bus_responder.sv | 230 +++++++++++++++++++++++
 tb/tb_io_bus_responder.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/io_bus_responder.sv
// io_bus_responder
//   Memory-mapped responder on the CPU IO bus. Decodes word addresses into
//   an LED register, switch readback, an output FIFO with status, a
//   single-entry input mailbox and a free-running cycle counter. The FIFO
//   and mailbox bridge the CPU to board-side logic through valid/ready
//   handshakes; everything runs in the CPU clock domain.
//
// Ports
//   clk        CPU clock
//   rstn       asynchronous active-low reset
//   io_addr    byte address, only io_addr[7:0] is decoded
//   io_dout    CPU write data
//   io_we      write strobe, sampled on rising clk
//   io_rd      read strobe, read side effects commit on rising clk
//   io_din     read data, combinational from io_addr and current state
//   led        LED register
//   sw         switch levels
//   out_data   output FIFO head
//   out_valid  output FIFO non-empty
//   out_ready  consumer accepts the head this cycle
//   in_data    producer data
//   in_valid   producer has data
//   in_ready   mailbox empty (driven from registered state only)

module io_bus_responder #(
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = 32
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic [15:0] io_addr,
  input  logic [31:0] io_dout,
  input  logic        io_we,
  input  logic        io_rd,
  output logic [31:0] io_din,
  output logic [15:0] led,
  input  logic [15:0] sw,
  output logic [31:0] out_data,
  output logic        out_valid,
  input  logic        out_ready,
  input  logic [31:0] in_data,
  input  logic        in_valid,
  output logic        in_ready
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  localparam logic [7:0] ADDR_LED   = 8'h00;
  localparam logic [7:0] ADDR_SW    = 8'h04;
  localparam logic [7:0] ADDR_OSTAT = 8'h08;
  localparam logic [7:0] ADDR_ODATA = 8'h0C;
  localparam logic [7:0] ADDR_ISTAT = 8'h10;
  localparam logic [7:0] ADDR_IDATA = 8'h14;
  localparam logic [7:0] ADDR_CYCLE = 8'h18;

  typedef enum logic {
    MB_EMPTY = 1'b0,
    MB_FULL  = 1'b1
  } mb_state_t;

  logic [7:0]    addr_lo;
  logic          unused_addr_hi;

  logic [31:0]   mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          full;
  logic          ovf;
  logic          push_req;
  logic          push_ok;
  logic          pop;
  logic          ovf_clear;

  mb_state_t     mb_state;
  mb_state_t     mb_next;
  logic          mb_capture;
  logic          mb_clear_req;
  logic [31:0]   mb_data;
  logic          in_full;

  logic [CNT_W-1:0] cycle_cnt;
  logic [31:0]      cycle_ext;

  // The upper address byte is not part of the map; fold it away so the
  // decode only ever looks at the low byte.
  assign addr_lo        = io_addr[7:0];
  assign unused_addr_hi = ^io_addr[15:8];

  // Bus strobes qualified by address.
  assign push_req     = io_we && (addr_lo == ADDR_ODATA);
  assign ovf_clear    = io_we && (addr_lo == ADDR_OSTAT) && io_dout[2];
  assign mb_clear_req = io_rd && (addr_lo == ADDR_IDATA);

  // FIFO flags. A push into a full FIFO is still accepted when the head is
  // leaving on the same edge, since the slot frees up in time.
  assign full      = (count == CW'(FIFO_DEPTH));
  assign out_valid = (count != '0);
  assign pop       = out_valid && out_ready;
  assign push_ok   = push_req && (!full || pop);
  assign out_data  = mem[rd_ptr];

  // LED register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      led <= '0;
    end else if (io_we && (addr_lo == ADDR_LED)) begin
      led <= io_dout[15:0];
    end
  end

  // FIFO storage and pointers. Pointer arithmetic wraps naturally because
  // the depth is a power of two.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem[i] <= '0;
      end
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push_ok) begin
        mem[wr_ptr] <= io_dout;
        wr_ptr      <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
    end
  end

  // Occupancy count; a simultaneous push and pop leaves it unchanged.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      count <= '0;
    end else begin
      case ({push_ok, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Sticky overflow: set when a push is dropped, cleared only by software.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ovf <= 1'b0;
    end else if (push_req && full && !pop) begin
      ovf <= 1'b1;
    end else if (ovf_clear) begin
      ovf <= 1'b0;
    end
  end

  // Mailbox state register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      mb_state <= MB_EMPTY;
    end else begin
      mb_state <= mb_next;
    end
  end

  // Mailbox next state. Capture only happens from EMPTY, so the edge that
  // clears the mailbox can never also refill it.
  always_comb begin
    mb_next    = mb_state;
    mb_capture = 1'b0;
    case (mb_state)
      MB_EMPTY: begin
        if (in_valid) begin
          mb_capture = 1'b1;
          mb_next    = MB_FULL;
        end
      end
      MB_FULL: begin
        if (mb_clear_req) begin
          mb_next = MB_EMPTY;
        end
      end
      default: mb_next = MB_EMPTY;
    endcase
  end

  // Mailbox data keeps its last value after being read so that a stale
  // IDATA read returns it unchanged.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      mb_data <= '0;
    end else if (mb_capture) begin
      mb_data <= in_data;
    end
  end

  assign in_full  = (mb_state == MB_FULL);
  assign in_ready = (mb_state == MB_EMPTY);

  // Free-running cycle counter, wrapping at 2^CNT_W.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cycle_cnt <= '0;
    end else begin
      cycle_cnt <= cycle_cnt + CNT_W'(1);
    end
  end

  // Zero-extend the counter to the bus width for any legal CNT_W.
  always_comb begin
    cycle_ext              = '0;
    cycle_ext[CNT_W-1:0]   = cycle_cnt;
  end

  // Read mux. Purely combinational, so a read with a concurrent write
  // returns the state from before the write.
  always_comb begin
    io_din = '0;
    case (addr_lo)
      ADDR_LED:   io_din = {16'b0, led};
      ADDR_SW:    io_din = {16'b0, sw};
      ADDR_OSTAT: io_din = {29'b0, ovf, full, ~full};
      ADDR_ISTAT: io_din = {31'b0, in_full};
      ADDR_IDATA: io_din = mb_data;
      ADDR_CYCLE: io_din = cycle_ext;
      default:    io_din = '0;
    endcase
  end

endmodule

// File: tb/tb_io_bus_responder.sv
module tb_io_bus_responder;

  logic        clk = 1'b0;
  logic        rstn;
  logic [15:0] io_addr;
  logic [31:0] io_dout;
  logic        io_we;
  logic        io_rd;
  logic [31:0] io_din;
  logic [15:0] led;
  logic [15:0] sw;
  logic [31:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] in_data;
  logic        in_valid;
  logic        in_ready;

  int          vectors     = 0;
  int          miscompares = 0;
  logic [31:0] exp_q[$];
  int          model_count = 0;
  logic        model_ovf   = 1'b0;

  always #5 clk = ~clk;

  io_bus_responder #(.FIFO_DEPTH(4), .CNT_W(32)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .io_addr   (io_addr),
    .io_dout   (io_dout),
    .io_we     (io_we),
    .io_rd     (io_rd),
    .io_din    (io_din),
    .led       (led),
    .sw        (sw),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready)
  );

  // One comparison: counts it and reports any miscompare.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
    end
  endtask

  // One bus cycle driven at the falling edge, committed at the next rising edge.
  task automatic applyStimulus(input logic we, input logic rd,
                               input logic [15:0] addr, input logic [31:0] data);
    @(negedge clk);
    io_we   = we;
    io_rd   = rd;
    io_addr = addr;
    io_dout = data;
    @(posedge clk);
    #1;
    io_we = 1'b0;
    io_rd = 1'b0;
  endtask

  // Side-effect-free combinational read.
  task automatic readCheck(input logic [15:0] addr, input logic [31:0] expected,
                           input string tag);
    @(negedge clk);
    io_we   = 1'b0;
    io_rd   = 1'b0;
    io_addr = addr;
    #1;
    checkOutput(tag, io_din, expected);
  endtask

  // Push with the consumer stalled; the scoreboard mirrors accept/drop.
  task automatic fifoPush(input logic [31:0] d);
    if (model_count < 4) begin
      exp_q.push_back(d);
      model_count++;
    end else begin
      model_ovf = 1'b1;
    end
    applyStimulus(1'b1, 1'b0, 16'h000C, d);
  endtask

  function automatic logic [31:0] ostatModel();
    return {29'b0, model_ovf, (model_count == 4), (model_count != 4)};
  endfunction

  // Pop one entry per cycle for a bounded number of cycles.
  task automatic drainFifo(input int max_cycles);
    for (int i = 0; i < max_cycles; i++) begin
      @(negedge clk);
      out_ready = 1'b1;
      #1;
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          checkOutput("fifo_extra_valid", {31'b0, out_valid}, 32'h0);
        end else begin
          checkOutput("fifo_head", out_data, exp_q.pop_front());
          model_count--;
        end
      end
    end
    @(negedge clk);
    out_ready = 1'b0;
    #1;
    checkOutput("fifo_drained_q", exp_q.size(), 32'h0);
    checkOutput("fifo_drained_valid", {31'b0, out_valid}, 32'h0);
  endtask

  initial begin
    rstn      = 1'b0;
    io_addr   = '0;
    io_dout   = '0;
    io_we     = 1'b0;
    io_rd     = 1'b0;
    sw        = '0;
    out_ready = 1'b0;
    in_data   = '0;
    in_valid  = 1'b0;

    // T1 reset state
    #12;
    io_addr = 16'h0008;
    #1;
    checkOutput("rst_led", {16'b0, led}, 32'h0);
    checkOutput("rst_out_valid", {31'b0, out_valid}, 32'h0);
    checkOutput("rst_in_ready", {31'b0, in_ready}, 32'h1);
    checkOutput("rst_ostat", io_din, 32'h1);
    io_addr = 16'h001C;
    #1;
    checkOutput("rst_unmapped", io_din, 32'h0);
    @(negedge clk);
    rstn    = 1'b1;
    io_addr = 16'h0018;
    #1;
    checkOutput("cycle_start", io_din, 32'h0);
    @(posedge clk);
    #1;
    checkOutput("cycle_first", io_din, 32'h1);
    @(posedge clk);
    #1;
    checkOutput("cycle_second", io_din, 32'h2);

    // T2 LED / SW / decode
    applyStimulus(1'b1, 1'b0, 16'h0000, 32'hDEADBEEF);
    checkOutput("led_write", {16'b0, led}, 32'h0000BEEF);
    readCheck(16'h0000, 32'h0000BEEF, "led_read");
    sw = 16'h1234;
    readCheck(16'h0004, 32'h00001234, "sw_read");
    applyStimulus(1'b1, 1'b0, 16'h0020, 32'h0000FFFF);
    checkOutput("unmapped_write", {16'b0, led}, 32'h0000BEEF);
    applyStimulus(1'b1, 1'b0, 16'h0100, 32'h00005555);
    checkOutput("addr_hi_ignored", {16'b0, led}, 32'h00005555);
    @(negedge clk);
    io_we   = 1'b1;
    io_rd   = 1'b1;
    io_addr = 16'h0000;
    io_dout = 32'h00001111;
    #1;
    checkOutput("rw_pre_write", io_din, 32'h00005555);
    @(posedge clk);
    #1;
    io_we = 1'b0;
    io_rd = 1'b0;
    checkOutput("rw_post_write", {16'b0, led}, 32'h00001111);

    // T3 FIFO fill and overflow
    readCheck(16'h0008, ostatModel(), "ostat_empty");
    for (int i = 1; i <= 5; i++) fifoPush(i);
    readCheck(16'h0008, ostatModel(), "ostat_ovf_full");
    checkOutput("head_stable", out_data, 32'h1);
    applyStimulus(1'b1, 1'b0, 16'h0008, 32'h00000004);
    model_ovf = 1'b0;
    readCheck(16'h0008, ostatModel(), "ostat_ovf_clr");
    drainFifo(6);

    // T4 full with simultaneous push and pop
    for (int i = 10; i <= 13; i++) fifoPush(i);
    @(negedge clk);
    out_ready = 1'b1;
    io_we     = 1'b1;
    io_addr   = 16'h000C;
    io_dout   = 32'd9;
    #1;
    checkOutput("t4_head", out_data, exp_q.pop_front());
    exp_q.push_back(32'd9);
    @(posedge clk);
    #1;
    io_we     = 1'b0;
    out_ready = 1'b0;
    readCheck(16'h0008, ostatModel(), "t4_ostat");
    drainFifo(6);

    // T5 mailbox
    readCheck(16'h0010, 32'h0, "istat_empty");
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = 32'h000000A5;
    @(posedge clk);
    #1;
    in_data = 32'h0000005A;
    checkOutput("mb_in_ready_full", {31'b0, in_ready}, 32'h0);
    readCheck(16'h0010, 32'h1, "istat_full");
    readCheck(16'h0014, 32'h000000A5, "idata_held");
    @(negedge clk);
    io_rd   = 1'b1;
    io_addr = 16'h0014;
    #1;
    checkOutput("idata_read", io_din, 32'h000000A5);
    @(posedge clk);
    #1;
    io_rd = 1'b0;
    checkOutput("mb_no_capture_on_clear", {31'b0, in_ready}, 32'h1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    checkOutput("mb_second_capture", {31'b0, in_ready}, 32'h0);
    readCheck(16'h0014, 32'h0000005A, "idata_second");
    applyStimulus(1'b0, 1'b1, 16'h0014, 32'h0);
    readCheck(16'h0010, 32'h0, "istat_cleared");
    applyStimulus(1'b0, 1'b1, 16'h0014, 32'h0);
    readCheck(16'h0014, 32'h0000005A, "idata_empty_read");
    checkOutput("mb_empty_ready", {31'b0, in_ready}, 32'h1);

    // T6 async reset with live FIFO and mailbox state
    for (int i = 20; i <= 24; i++) fifoPush(i);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      out_ready = 1'b1;
      #1;
      checkOutput("t6_head", out_data, exp_q.pop_front());
      model_count--;
    end
    @(negedge clk);
    out_ready = 1'b0;
    readCheck(16'h0008, ostatModel(), "t6_ostat_pre");
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = 32'h00000077;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    checkOutput("t6_mb_full", {31'b0, in_ready}, 32'h0);
    @(negedge clk);
    io_addr = 16'h0008;
    #2;
    rstn = 1'b0;
    #1;
    exp_q.delete();
    model_count = 0;
    model_ovf   = 1'b0;
    checkOutput("t6_out_valid", {31'b0, out_valid}, 32'h0);
    checkOutput("t6_ostat", io_din, ostatModel());
    checkOutput("t6_in_ready", {31'b0, in_ready}, 32'h1);
    checkOutput("t6_led", {16'b0, led}, 32'h0);
    @(negedge clk);
    rstn = 1'b1;
    readCheck(16'h0014, 32'h0, "t6_idata");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
